// File: rtl/sound_sequencer_if.sv
// sound_sequencer_if: request, step-table and generator-control bundle of the sound sequencer
// Signals:
//   req[3:0]            one-cycle effect request pulses (bit 3 highest priority)
//   cfg_we/addr/data    step-table write port (65-bit words, 73-bit with SOUND_SEQUENCER_SWEEP_EN)
//   busy, cur_effect    playback status; cur_effect valid while busy
//   done[3:0]           one-cycle pulse when an effect completes normally
//   gen_reset           reset to the sound generator
//   vco1/vco2/noise_freq, lfo_freq, *_select, lfo_shift, mixer   generator controls
// Modports: master = game logic side, slave = sequencer side.
interface sound_sequencer_if;
`ifdef SOUND_SEQUENCER_SWEEP_EN
    localparam int CFG_W = 73;
`else
    localparam int CFG_W = 65;
`endif
    logic [3:0]       req;
    logic             cfg_we;
    logic [3:0]       cfg_addr;
    logic [CFG_W-1:0] cfg_data;
    logic             busy;
    logic [1:0]       cur_effect;
    logic [3:0]       done;
    logic             gen_reset;
    logic [11:0]      vco1_freq;
    logic [11:0]      vco2_freq;
    logic [11:0]      noise_freq;
    logic [9:0]       lfo_freq;
    logic             vco1_select;
    logic             vco2_select;
    logic             noise_select;
    logic [2:0]       lfo_shift;
    logic [3:0]       mixer;

    modport master (
        output req, cfg_we, cfg_addr, cfg_data,
        input  busy, cur_effect, done, gen_reset, vco1_freq, vco2_freq, noise_freq,
               lfo_freq, vco1_select, vco2_select, noise_select, lfo_shift, mixer
    );

    modport slave (
        input  req, cfg_we, cfg_addr, cfg_data,
        output busy, cur_effect, done, gen_reset, vco1_freq, vco2_freq, noise_freq,
               lfo_freq, vco1_select, vco2_select, noise_select, lfo_shift, mixer
    );
endinterface

// File: rtl/sound_sequencer.sv
// sound_sequencer: plays prioritised sound-effect patches step by step on an SN76477-style generator
// Ports:
//   clk     system clock
//   reset   asynchronous active-high reset
//   bus     sound_sequencer_if.slave: req/cfg_* in; busy, cur_effect, done, gen_reset and
//           every generator control out (all registered)
// Parameter TICK_DIV: clocks per duration tick (>= 2).
// Optional: define SOUND_SEQUENCER_SWEEP_EN for a signed 8-bit per-step vco1 sweep
// (step words grow from 65 to 73 bits, sweep in the top byte).
module sound_sequencer #(
    parameter int TICK_DIV = 416667
) (
    input  logic             clk,
    input  logic             reset,
    sound_sequencer_if.slave bus
);
`ifdef SOUND_SEQUENCER_SWEEP_EN
    localparam int CW = 73;
`else
    localparam int CW = 65;
`endif
    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {IDLE, LOAD, PLAY} state_t;

    state_t        state;
    logic [CW-1:0] tbl [16];
    logic [CW-1:0] w;
    logic [3:0]    pend, eff, nbit, at_or_above;
    logic [1:0]    cur, nxt, step;
    logic [8:0]    dur_cnt;
    logic [PW-1:0] presc;
    logic          last_r, tick;
`ifdef SOUND_SEQUENCER_SWEEP_EN
    logic [7:0]    sweep_r;
    logic [13:0]   vsum;
`endif

    assign bus.cur_effect = cur;

    // Step table has no reset; a write lands before the next LOAD that reads it.
    always_ff @(posedge clk) if (bus.cfg_we) tbl[bus.cfg_addr] <= bus.cfg_data;

    always_comb begin
        eff = pend | bus.req;
        nxt = eff[3] ? 2'd3 : eff[2] ? 2'd2 : eff[1] ? 2'd1 : 2'd0;
        nbit = 4'b0001 << nxt;
        // Requests at or above the playing effect: above preempts, equal retriggers.
        at_or_above = eff & ~((4'b0001 << cur) - 4'd1);
        w = tbl[{cur, step}];
        tick = presc == '0;
    end

`ifdef SOUND_SEQUENCER_SWEEP_EN
    // Bit 13 flags a negative sum, bit 12 an overflow past 4095.
    assign vsum = {2'b00, bus.vco1_freq} + {{6{sweep_r[7]}}, sweep_r};
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= IDLE;
            pend             <= '0;
            cur              <= '0;
            step             <= '0;
            dur_cnt          <= '0;
            presc            <= '0;
            last_r           <= 1'b0;
            bus.busy         <= 1'b0;
            bus.done         <= '0;
            bus.gen_reset    <= 1'b0;
            bus.vco1_freq    <= '0;
            bus.vco2_freq    <= '0;
            bus.noise_freq   <= '0;
            bus.lfo_freq     <= '0;
            bus.vco1_select  <= 1'b0;
            bus.vco2_select  <= 1'b0;
            bus.noise_select <= 1'b0;
            bus.lfo_shift    <= '0;
            bus.mixer        <= '0;
`ifdef SOUND_SEQUENCER_SWEEP_EN
            sweep_r          <= '0;
`endif
        end else begin
            bus.done      <= '0;
            bus.gen_reset <= 1'b0;
            pend          <= eff;
            case (state)
                IDLE: if (|eff) begin
                    cur   <= nxt;
                    step  <= '0;
                    pend  <= eff & ~nbit;
                    state <= LOAD;
                end
                LOAD: begin
                    bus.vco1_freq  <= w[11:0];
                    bus.vco2_freq  <= w[23:12];
                    bus.noise_freq <= w[35:24];
                    bus.lfo_freq   <= w[45:36];
                    {bus.vco1_select, bus.vco2_select, bus.noise_select} <= w[48:46];
                    bus.lfo_shift  <= w[51:49];
                    bus.mixer      <= w[55:52];
                    last_r         <= w[64];
`ifdef SOUND_SEQUENCER_SWEEP_EN
                    sweep_r        <= w[72:65];
`endif
                    dur_cnt        <= (w[63:56] == 8'd0) ? 9'd256 : {1'b0, w[63:56]};
                    presc          <= PRE_MAX;
                    bus.busy       <= 1'b1;
                    bus.gen_reset  <= (step == 2'd0);
                    state          <= PLAY;
                end
                PLAY: if (|at_or_above) begin
                    cur   <= nxt;
                    step  <= '0;
                    pend  <= eff & ~nbit;
                    state <= LOAD;
                end else if (tick) begin
                    presc   <= PRE_MAX;
                    dur_cnt <= dur_cnt - 9'd1;
`ifdef SOUND_SEQUENCER_SWEEP_EN
                    bus.vco1_freq <= vsum[13] ? 12'd0 : vsum[12] ? 12'hfff : vsum[11:0];
`endif
                    if (dur_cnt == 9'd1) begin
                        if (last_r || step == 2'd3) begin
                            bus.done <= 4'b0001 << cur;
                            if (|eff) begin
                                cur   <= nxt;
                                step  <= '0;
                                pend  <= eff & ~nbit;
                                state <= LOAD;
                            end else begin
                                state     <= IDLE;
                                bus.busy  <= 1'b0;
                                bus.mixer <= '0;
                            end
                        end else begin
                            step  <= step + 2'd1;
                            state <= LOAD;
                        end
                    end
                end else begin
                    presc <= presc - PW'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sound_sequencer.sv
// tb_sound_sequencer: self-checking bench for sound_sequencer against a step-timing reference model
// Ports: none (top level). Honours SOUND_SEQUENCER_SWEEP_EN for the sweep scenario.
module tb_sound_sequencer;
    localparam int TD = 4;
`ifdef SOUND_SEQUENCER_SWEEP_EN
    localparam int CW = 73;
`else
    localparam int CW = 65;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int fails = 0;

    sound_sequencer_if bus();
    sound_sequencer #(.TICK_DIV(TD)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    // Reference model: an effect is a chain of steps, each lasting dur*TD+1 clocks
    // (the first being the load clock), counted down with a plain clock counter.
    logic [CW-1:0] mt [16];
    bit            act, ld;
    int            m_cur, m_step, left, m_len;
    logic [3:0]    pend;
    logic          e_busy, e_gr, e_last;
    logic [3:0]    e_done, e_mix;
    logic [11:0]   e_v1, e_v2, e_nz;
    logic [9:0]    e_lfo;
    logic [2:0]    e_sel, e_sh;
    logic [7:0]    e_sw;

    function automatic logic [CW-1:0] mk(input logic [7:0] sw, input logic last, input logic [7:0] dur,
                                         input logic [3:0] mix, input logic [2:0] sh, input logic [2:0] sel,
                                         input logic [9:0] lfo, input logic [11:0] nz, input logic [11:0] v2,
                                         input logic [11:0] v1);
        logic [72:0] x;
        x = {sw, last, dur, mix, sh, sel, lfo, nz, v2, v1};
        return x[CW-1:0];
    endfunction

    function automatic logic [CW-1:0] rnd_word();
        return mk(8'($urandom), 1'($urandom_range(0, 1)), 8'($urandom_range(1, 3)), 4'($urandom),
                  3'($urandom), 3'($urandom), 10'($urandom), 12'($urandom), 12'($urandom), 12'($urandom));
    endfunction

    function automatic int highest(input logic [3:0] v);
        int k = 0;
        for (int i = 0; i < 4; i++) if (v[i]) k = i;
        return k;
    endfunction

    function automatic logic [63:0] obs();
        return {bus.busy, bus.busy ? bus.cur_effect : 2'd0, bus.done, bus.gen_reset, bus.vco1_freq,
                bus.vco2_freq, bus.noise_freq, bus.lfo_freq, bus.vco1_select, bus.vco2_select,
                bus.noise_select, bus.lfo_shift, bus.mixer};
    endfunction

    function automatic logic [63:0] expv();
        return {e_busy, e_busy ? 2'(m_cur) : 2'd0, e_done, e_gr, e_v1, e_v2, e_nz, e_lfo, e_sel, e_sh, e_mix};
    endfunction

    task automatic model_reset();
        act = 0; ld = 0; m_cur = 0; m_step = 0; left = 0; m_len = 0; pend = '0;
        e_busy = 0; e_gr = 0; e_last = 0; e_done = '0; e_mix = '0;
        e_v1 = '0; e_v2 = '0; e_nz = '0; e_lfo = '0; e_sel = '0; e_sh = '0; e_sw = '0;
    endtask

    task automatic start(input logic [3:0] eff);
        m_cur = highest(eff);
        m_step = 0;
        pend = eff & ~(4'b0001 << m_cur);
        ld = 1;
        act = 1;
    endtask

    task automatic model_edge(input logic [3:0] r, input logic we, input logic [3:0] a, input logic [CW-1:0] d);
        logic [3:0]    eff;
        logic [CW-1:0] w;
        int            s, dd;
        eff = pend | r;
        e_done = '0;
        e_gr = 0;
        if (!act) begin
            if (eff != 0) start(eff);
            else pend = eff;
        end else if (ld) begin
            w = mt[m_cur*4 + m_step];
            e_v1 = w[11:0]; e_v2 = w[23:12]; e_nz = w[35:24]; e_lfo = w[45:36];
            e_sel = w[48:46]; e_sh = w[51:49]; e_mix = w[55:52]; e_last = w[64];
`ifdef SOUND_SEQUENCER_SWEEP_EN
            e_sw = w[72:65];
`endif
            dd = int'(w[63:56]);
            if (dd == 0) dd = 256;
            m_len = dd * TD + 1;
            left = m_len - 1;
            e_busy = 1;
            e_gr = (m_step == 0);
            ld = 0;
            pend = eff;
        end else if ((eff >> m_cur) != 0) begin
            start(eff);
        end else begin
            pend = eff;
            left--;
`ifdef SOUND_SEQUENCER_SWEEP_EN
            if ((m_len - 1 - left) % TD == 0) begin
                s = int'(e_v1) + int'($signed(e_sw));
                e_v1 = (s < 0) ? 12'd0 : (s > 4095) ? 12'd4095 : 12'(s);
            end
`endif
            if (left == 0) begin
                if (e_last || m_step == 3) begin
                    e_done[m_cur] = 1'b1;
                    if (eff != 0) start(eff);
                    else begin
                        act = 0; e_busy = 0; e_mix = '0;
                    end
                end else begin
                    m_step++;
                    ld = 1;
                end
            end
        end
        if (we) mt[a] = d;
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge(bus.req, bus.cfg_we, bus.cfg_addr, bus.cfg_data);
        #1;
        bus.req = '0;
        bus.cfg_we = 1'b0;
    endtask

    task automatic wr(input int a, input logic [CW-1:0] d);
        bus.cfg_we = 1'b1;
        bus.cfg_addr = 4'(a);
        bus.cfg_data = d;
        cyc();
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (obs() !== 64'd0) begin
            fails++; $display("FAIL reset_state dut=%h want=0", obs());
        end
        reset = 1'b0;
        wr(0, mk(0, 0, 2, 4'b0001, 0, 0, 0, 0, 0, 12'd100));
        wr(1, mk(0, 1, 1, 4'b0001, 0, 0, 0, 0, 0, 12'd200));
        wr(8, mk(0, 0, 3, 4'b0010, 3'd1, 3'b101, 10'd7, 12'd9, 12'd8, 12'd300));
        wr(9, mk(0, 1, 1, 4'b0100, 0, 0, 0, 0, 0, 12'd301));
        bus.req = 4'b0100;
        for (int i = 0; i < 8; i++) begin
            if (i == 4) bus.req = 4'b0001;
            cyc();
            checks++;
            if (obs() !== expv()) begin
                fails++; $display("FAIL reset_play i=%0d dut=%h model=%h", i, obs(), expv());
            end
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({bus.busy, bus.mixer, bus.gen_reset, bus.done} !== 10'd0) begin
            fails++;
            $display("FAIL reset_async busy=%b mixer=%h gen_reset=%b done=%h want all 0",
                     bus.busy, bus.mixer, bus.gen_reset, bus.done);
        end
        model_reset();
        @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cyc();
            checks++;
            if (obs() !== expv()) begin
                fails++; $display("FAIL reset_pend_cleared i=%0d dut=%h model=%h", i, obs(), expv());
            end
        end
        bus.req = 4'b0001;
        for (int i = 0; i < 16; i++) begin
            cyc();
            checks++;
            if (obs() !== expv()) begin
                fails++; $display("FAIL reset_restart i=%0d dut=%h model=%h", i, obs(), expv());
            end
        end
    endtask

    task automatic test_basic();
        int g = -1, v = -1, dn = -1, ng = 0, nd = 0;
        bus.req = 4'b0001;
        for (int i = 0; i < 18; i++) begin
            cyc();
            checks++;
            if (obs() !== expv()) begin
                fails++; $display("FAIL basic i=%0d dut=%h model=%h", i, obs(), expv());
            end
            if (bus.gen_reset) begin ng++; if (g < 0) g = i; end
            if (bus.busy && bus.vco1_freq == 12'd200 && v < 0) v = i;
            if (bus.done != 0) begin nd++; dn = i; end
        end
        checks++;
        if (ng != 1 || nd != 1 || bus.done !== 4'd0) begin
            fails++; $display("FAIL basic_pulses gen_reset=%0d done=%0d want 1 1", ng, nd);
        end
        checks++;
        if (v - g != 9 || dn - v != 4) begin
            fails++; $display("FAIL basic_timing step0=%0d step1_play=%0d want 9 4", v - g, dn - v);
        end
        checks++;
        if (bus.busy !== 1'b0 || bus.mixer !== 4'd0) begin
            fails++; $display("FAIL basic_end busy=%b mixer=%h want 0 0", bus.busy, bus.mixer);
        end
    endtask

    task automatic test_preempt();
        int c3 = -1, g3 = -1, n1 = 0, n3 = 0;
        wr(4, mk(0, 1, 10, 4'b0011, 3'd2, 3'b010, 10'd100, 12'd50, 12'd60, 12'd500));
        wr(12, mk(0, 1, 2, 4'b1000, 3'd4, 3'b001, 10'd33, 12'd44, 12'd55, 12'd900));
        bus.req = 4'b0010;
        for (int i = 0; i < 32; i++) begin
            if (i == 13) bus.req = 4'b1000;
            cyc();
            checks++;
            if (obs() !== expv()) begin
                fails++; $display("FAIL preempt i=%0d dut=%h model=%h", i, obs(), expv());
            end
            if (i >= 13 && bus.busy && bus.cur_effect == 2'd3 && c3 < 0) c3 = i;
            if (i >= 13 && bus.gen_reset && g3 < 0) g3 = i;
            if (bus.done[1]) n1++;
            if (bus.done[3]) n3++;
        end
        checks++;
        if (c3 < 13 || c3 > 14 || g3 < 13 || g3 > 14) begin
            fails++; $display("FAIL preempt_latency cur3_at=%0d gen_reset_at=%0d want 13..14", c3, g3);
        end
        checks++;
        if (n1 != 0 || n3 != 1) begin
            fails++; $display("FAIL preempt_done done1=%0d done3=%0d want 0 1", n1, n3);
        end
    endtask

    task automatic test_back_to_back();
        int d3 = -1, g0 = -1;
        logic busy_at_done = 1'b0;
        bus.req = 4'b1000;
        for (int i = 0; i < 30; i++) begin
            if (i == 4) bus.req = 4'b0001;
            cyc();
            checks++;
            if (obs() !== expv()) begin
                fails++; $display("FAIL back_to_back i=%0d dut=%h model=%h", i, obs(), expv());
            end
            if (bus.done[3]) begin d3 = i; busy_at_done = bus.busy; end
            if (d3 >= 0 && bus.gen_reset && g0 < 0) g0 = i;
        end
        checks++;
        if (d3 < 0 || g0 != d3 + 1 || busy_at_done !== 1'b1) begin
            fails++; $display("FAIL back_to_back_gap done3_at=%0d gen_reset_at=%0d busy=%b want next cycle, busy 1",
                              d3, g0, busy_at_done);
        end
    endtask

    task automatic test_dur0_chain();
        int a = -1, b = -1, c = -1, dn = -1, nd = 0;
        wr(8, mk(0, 0, 0, 4'b0110, 0, 0, 0, 0, 0, 12'd10));
        wr(9, mk(0, 0, 1, 4'b0110, 0, 0, 0, 0, 0, 12'd11));
        wr(10, mk(0, 0, 1, 4'b0110, 0, 0, 0, 0, 0, 12'd12));
        wr(11, mk(0, 0, 1, 4'b0110, 0, 0, 0, 0, 0, 12'd13));
        bus.req = 4'b0100;
        for (int i = 0; i < 1050; i++) begin
            cyc();
            checks++;
            if (obs() !== expv()) begin
                fails++; $display("FAIL dur0_chain i=%0d dut=%h model=%h", i, obs(), expv());
            end
            if (bus.busy && bus.vco1_freq == 12'd10 && a < 0) a = i;
            if (bus.busy && bus.vco1_freq == 12'd11 && b < 0) b = i;
            if (bus.busy && bus.vco1_freq == 12'd13 && c < 0) c = i;
            if (bus.done[2]) begin nd++; dn = i; end
        end
        checks++;
        if (b - a != 1025) begin
            fails++; $display("FAIL dur0_length got=%0d want=1025", b - a);
        end
        checks++;
        if (nd != 1 || dn - c != 4) begin
            fails++; $display("FAIL chain_done count=%0d after_step3=%0d want 1 4", nd, dn - c);
        end
    endtask

`ifdef SOUND_SEQUENCER_SWEEP_EN
    task automatic test_sweep();
        logic [11:0] got [4];
        wr(0, mk(8'd4, 1, 5, 4'b0001, 0, 0, 0, 0, 0, 12'd4090));
        bus.req = 4'b0001;
        for (int i = 0; i < 24; i++) begin
            cyc();
            checks++;
            if (obs() !== expv()) begin
                fails++; $display("FAIL sweep_up i=%0d dut=%h model=%h", i, obs(), expv());
            end
            if (i == 1) got[0] = bus.vco1_freq;
            if (i == 5) got[1] = bus.vco1_freq;
            if (i == 9) got[2] = bus.vco1_freq;
            if (i == 13) got[3] = bus.vco1_freq;
        end
        checks++;
        if (got[0] !== 12'd4090 || got[1] !== 12'd4094 || got[2] !== 12'd4095 || got[3] !== 12'd4095) begin
            fails++; $display("FAIL sweep_saturate got=%0d,%0d,%0d,%0d want 4090,4094,4095,4095",
                              got[0], got[1], got[2], got[3]);
        end
        wr(0, mk(8'h80, 1, 2, 4'b0001, 0, 0, 0, 0, 0, 12'd100));
        bus.req = 4'b0001;
        for (int i = 0; i < 14; i++) begin
            cyc();
            checks++;
            if (obs() !== expv()) begin
                fails++; $display("FAIL sweep_down i=%0d dut=%h model=%h", i, obs(), expv());
            end
            if (i == 5) got[0] = bus.vco1_freq;
        end
        checks++;
        if (got[0] !== 12'd0) begin
            fails++; $display("FAIL sweep_floor got=%0d want=0", got[0]);
        end
    endtask
`endif

    task automatic test_random();
        for (int a = 0; a < 16; a++) wr(a, rnd_word());
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) == 0) bus.req = 4'($urandom_range(1, 15));
            if ($urandom_range(0, 49) == 0) begin
                bus.cfg_we = 1'b1;
                bus.cfg_addr = 4'($urandom_range(0, 15));
                bus.cfg_data = rnd_word();
            end
            cyc();
            checks++;
            if (obs() !== expv()) begin
                fails++; $display("FAIL random i=%0d dut=%h model=%h", i, obs(), expv());
            end
        end
    endtask

    initial begin
        bus.req = '0;
        bus.cfg_we = 1'b0;
        bus.cfg_addr = '0;
        bus.cfg_data = '0;
        model_reset();
        test_reset();
        test_basic();
        test_preempt();
        test_back_to_back();
        test_dur0_chain();
`ifdef SOUND_SEQUENCER_SWEEP_EN
        test_sweep();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule

// File: doc/sound_sequencer.md
Name: sound_sequencer

Overview:
- Plays short sound effects on the SN76477-style sound generator by stepping through programmable "patch" steps (oscillator frequencies, selects, LFO depth, mixer, duration).
- Arbitrates up to four effect requesters, e.g. game events, by fixed priority with preemption.
- Sits between game logic and the sound generator and drives all of the generator's control inputs, including its reset.

Parameters:
- TICK_DIV, 416667: clocks per duration tick (60 Hz at 25 MHz); minimum 2.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- req  in  4  one-cycle effect request pulses; bit k = effect k; higher index = higher priority.
- cfg_we  in  1  step-table write strobe.
- cfg_addr  in  4  step index; effect k owns steps 4k..4k+3.
- cfg_data  in  65 (73 with SWEEP_EN)  step word, MSB first: {last, dur[7:0], mixer[3:0], lfo_shift[2:0], sel[2:0] (vco1, vco2, noise), lfo_freq[9:0], noise_freq[11:0], vco2_freq[11:0], vco1_freq[11:0]}; with SWEEP_EN, sweep[7:0] is prepended above last.
- busy  out  1  an effect is playing.
- cur_effect  out  2  effect currently playing; valid while busy.
- done  out  4  one-cycle pulse on bit k when effect k completes normally.
- gen_reset  out  1  reset to the sound generator.
- vco1_freq, vco2_freq, noise_freq  out  12 each  generator frequency controls.
- lfo_freq  out  10  generator LFO frequency control.
- vco1_select, vco2_select, noise_select  out  1 each  generator LFO-modulation selects.
- lfo_shift  out  3  generator LFO modulation depth.
- mixer  out  4  generator mixer enables.

Behaviour:
- Step table: 16 registered entries, no reset value; writable in any state. A write is seen at the next LOAD of that step.
- Pending register pend[3:0] is set by req. Effective request eff = pend | req.
- State machine: IDLE, LOAD, PLAY. All outputs are registered.
- Reset (async): state=IDLE, pend=0, busy=0, done=0, gen_reset=0, all generator outputs 0 (mixer=0 means silence), prescaler=0, step=0.
- IDLE: if eff≠0, select k = highest set bit, cur<=k, step<=0, clear pend[k], go to LOAD. Otherwise mixer stays 0.
- LOAD (one cycle): register all step fields to the outputs; dur_cnt <= dur, with 0 meaning 256; prescaler <= TICK_DIV-1; busy<=1; gen_reset<=1 only if step==0; go to PLAY.
- PLAY: gen_reset=0. The prescaler counts down and reaching 0 is a tick (reload TICK_DIV-1). On a tick dur_cnt decrements; on 1→0:
  - If last=1 or step==3, pulse done[cur]. Then go to LOAD if eff≠0 (selecting as in IDLE), else IDLE with busy=0 and mixer=0.
  - Otherwise step<=step+1 and go to LOAD.
- Step length: exactly D×TICK_DIV+1 clocks, including LOAD.
- Preemption in PLAY: if eff has a bit j>cur, abort cur immediately (no done), select j, clear pend[j], step=0, go to LOAD. Checked every cycle, with priority over tick handling.
- Retrigger: req[cur] during PLAY restarts cur from step 0 via LOAD (no done).
- Lower-priority requests during PLAY stay pending until the current effect finishes.
- Simultaneous completion and higher request: done pulses and the new effect loads, same as the completion path.
- Latency: req at edge E → LOAD at E+1 → outputs valid after edge E+2.

Optional Feature:
- Macro SOUND_SEQUENCER_SWEEP_EN.
- Defined: cfg_data is 73 bits with a signed 8-bit sweep per step. On each PLAY tick, vco1_freq <= vco1_freq + sign-extended sweep, saturating at 0 and 4095. LOAD reloads the table value.
- Undefined: cfg_data is 65 bits and vco1_freq stays constant within a step.

Test Plan (TICK_DIV=4):
1. Reset mid-PLAY → next cycle busy=0, mixer=0, pend=0; a later req[0] starts from step 0.
2. Load effect 0: step0 {vco1=100, mixer=0001, dur=2, last=0}, step1 {vco1=200, dur=1, last=1}; pulse req[0] → gen_reset high 1 cycle; vco1=100 for 9 clocks, then 200 for 5 clocks; done[0] pulses once; busy falls; mixer=0.
3. Effect 1 playing with dur=10; pulse req[3] at tick 3 → no done[1]; within 2 clocks cur_effect=3 and gen_reset pulses.
4. Effect 3 playing; pulse req[0] → effect 0 starts in the cycle after done[3], with no IDLE gap.
5. Step with dur=0 → step lasts 257×... i.e. 256×4+1=1025 clocks; step chain 4 steps with last=0 → done after step 3.
6. SWEEP_EN: vco1=4090, sweep=+4, dur=5 → 4094, 4095, 4095…; sweep=−128 from 100 → 0 after one tick.
